// File: rtl/mux_rr_stream.sv
// N-channel stream mux with a registered output slot, external-select or round-robin grant.
// Optional even-parity output enabled by defining MUX_PARITY_EN.
module mux_rr_stream #(
    parameter int WIDTH = 16,
    parameter int N_CH  = 4,
    parameter int SEL_W = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SEL_W-1:0]      out_ch
`ifdef MUX_PARITY_EN
    ,
    output logic                  out_par
`endif
);

    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] grant;
    logic [SEL_W-1:0] cand;
    logic             grant_ok;
    logic             load_en;
    logic             xfer;
    logic [WIDTH-1:0] grant_data;

    assign load_en = !out_valid || out_ready;

    always_comb begin
        grant    = '0;
        grant_ok = 1'b0;
        cand     = '0;
        if (!mode) begin
            if (int'(sel) < N_CH && in_valid[sel]) begin
                grant    = sel;
                grant_ok = 1'b1;
            end
        end else begin
            // Walk offsets from farthest to nearest so the nearest valid channel wins.
            for (int i = N_CH; i >= 1; i--) begin
                cand = SEL_W'((int'(rr_ptr) + i) % N_CH);
                if (in_valid[cand]) begin
                    grant    = cand;
                    grant_ok = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (grant == SEL_W'(k)) begin
                grant_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Reset wins over any handshake, so no channel is told it was accepted.
    assign xfer = grant_ok && load_en && !rst;

    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= SEL_W'(N_CH - 1);
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_ch    <= grant;
            rr_ptr    <= grant;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef MUX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            out_par <= 1'b0;
        end else if (xfer) begin
            out_par <= ^grant_data;
        end
    end
`endif

endmodule

// File: tb/tb_mux_rr_stream.sv
// Directed self-checking bench for mux_rr_stream (4 channels x 16 bits).
module tb_mux_rr_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic [63:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_ch;
`ifdef MUX_PARITY_EN
    logic        out_par;
`endif

    logic [15:0] ch_data [4];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mux_rr_stream #(.WIDTH(16), .N_CH(4), .SEL_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch)
`ifdef MUX_PARITY_EN
        ,
        .out_par   (out_par)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_data();
        in_data = {ch_data[3], ch_data[2], ch_data[1], ch_data[0]};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        ch_data[0] = 16'hA000;
        ch_data[1] = 16'hB111;
        ch_data[2] = 16'hC222;
        ch_data[3] = 16'hD333;
        drive_data();
        rst       = 1'b1;
        mode      = 1'b1;
        sel       = 2'd0;
        in_valid  = 4'hF;
        out_ready = 1'b1;

        // Reset held two cycles with every channel valid
        for (int c = 0; c < 2; c++) begin
            step();
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_out_data", 32'(out_data), 32'd0);
            check("rst_out_ch", 32'(out_ch), 32'd0);
            check("rst_in_ready", 32'(in_ready), 32'd0);
`ifdef MUX_PARITY_EN
            check("rst_out_par", 32'(out_par), 32'd0);
`endif
        end

        // External select of channel 2
        rst        = 1'b0;
        mode       = 1'b0;
        sel        = 2'd2;
        ch_data[2] = 16'hBEEF;
        drive_data();
        in_valid   = 4'b0100;
        #1;
        check("sel2_in_ready", 32'(in_ready), 32'h4);
        step();
        check("sel2_out_data", 32'(out_data), 32'hBEEF);
        check("sel2_out_ch", 32'(out_ch), 32'd2);
        check("sel2_out_valid", 32'(out_valid), 32'd1);

        // Selected channel not valid: no grant; held word drains, data kept
        sel      = 2'd1;
        in_valid = 4'b0100;
        #1;
        check("sel_idle_in_ready", 32'(in_ready), 32'd0);
        step();
        check("drain_out_valid", 32'(out_valid), 32'd0);
        check("drain_keep_data", 32'(out_data), 32'hBEEF);
        check("drain_keep_ch", 32'(out_ch), 32'd2);

        // Reset to restart the pointer, then round-robin with everyone valid
        rst = 1'b1;
        step();
        rst      = 1'b0;
        mode     = 1'b1;
        in_valid = 4'hF;
        for (int i = 0; i < 8; i++) begin
            step();
            check("rr_out_ch", 32'(out_ch), 32'(i % 4));
            check("rr_out_data", 32'(out_data), 32'(ch_data[i % 4]));
            check("rr_out_valid", 32'(out_valid), 32'd1);
        end

        // Drain, then round-robin on 4'b1010 with a stalled consumer
        in_valid = 4'b0000;
        step();
        check("rr_drain_valid", 32'(out_valid), 32'd0);
        in_valid  = 4'b1010;
        out_ready = 1'b0;
        #1;
        check("stall_first_ready", 32'(in_ready), 32'h2);
        step();
        check("stall_load_ch", 32'(out_ch), 32'd1);
        for (int c = 0; c < 2; c++) begin
            check("stall_in_ready", 32'(in_ready), 32'd0);
            step();
            check("stall_hold_ch", 32'(out_ch), 32'd1);
            check("stall_hold_data", 32'(out_data), 32'(ch_data[1]));
            check("stall_hold_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", 32'(in_ready), 32'h8);
        step();
        check("release_out_ch", 32'(out_ch), 32'd3);
        check("release_out_data", 32'(out_data), 32'(ch_data[3]));

        // Mid-stream reset discards the held word
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ch", 32'(out_ch), 32'd0);
        check("mid_rst_data", 32'(out_data), 32'd0);
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'h2);
        step();
        check("post_rst_out_ch", 32'(out_ch), 32'd1);

`ifdef MUX_PARITY_EN
        mode       = 1'b0;
        sel        = 2'd0;
        in_valid   = 4'b0001;
        ch_data[0] = 16'h0007;
        drive_data();
        step();
        check("par_0007", 32'(out_par), 32'd1);
        ch_data[0] = 16'h0003;
        drive_data();
        step();
        check("par_0003", 32'(out_par), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
